// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the control unit: bus widths, FSM state encoding,
// opcode map, MUX select codes, C-bus write-enable bit indices, ALU op codes,
// the packed control-output bundle and small decode helpers.
// ---------------------------------------------------------------------------
package ctrl_pkg;

  localparam int INSTRUCTION_LEN = 6;
  localparam int C_BUS_SIG_LEN   = 11;
  localparam int MUX_SEL_SIG     = 4;
  localparam int ALU_OP_LEN      = 2;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_F1A  = 3'd1;
  localparam logic [2:0] ST_F1B  = 3'd2;
  localparam logic [2:0] ST_F2   = 3'd3;
  localparam logic [2:0] ST_F3   = 3'd4;
  localparam logic [2:0] ST_DEC  = 3'd5;
  localparam logic [2:0] ST_EXEC = 3'd6;
  localparam logic [2:0] ST_HALT = 3'd7;

  // Opcode map
  localparam logic [5:0] OP_NOP   = 6'h00;
  localparam logic [5:0] OP_LDAC  = 6'h01;
  localparam logic [5:0] OP_STAC  = 6'h02;
  localparam logic [5:0] OP_MVR1  = 6'h03;
  localparam logic [5:0] OP_MVR2  = 6'h04;
  localparam logic [5:0] OP_MVR3  = 6'h05;
  localparam logic [5:0] OP_MVAC1 = 6'h06;
  localparam logic [5:0] OP_MVAC2 = 6'h07;
  localparam logic [5:0] OP_MVAC3 = 6'h08;
  localparam logic [5:0] OP_ADD   = 6'h09;
  localparam logic [5:0] OP_SUB   = 6'h0A;
  localparam logic [5:0] OP_INCAC = 6'h0B;
  localparam logic [5:0] OP_INCRA = 6'h0C;
  localparam logic [5:0] OP_INCRB = 6'h0D;
  localparam logic [5:0] OP_INCRC = 6'h0E;
  localparam logic [5:0] OP_JMPZ  = 6'h0F;
  localparam logic [5:0] OP_JMP   = 6'h10;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  typedef enum logic [3:0] {
    SEL_PC = 4'd0, SEL_DR = 4'd1, SEL_R1 = 4'd2, SEL_R2 = 4'd3, SEL_R3 = 4'd4,
    SEL_RA = 4'd5, SEL_RB = 4'd6, SEL_RC = 4'd7, SEL_RD = 4'd8, SEL_AC = 4'd9
  } sel_e;

  typedef enum logic [3:0] {
    CB_AC = 4'd0, CB_AR = 4'd1, CB_DR = 4'd2, CB_R3 = 4'd3, CB_R2 = 4'd4, CB_R1 = 4'd5,
    CB_RC = 4'd6, CB_RB = 4'd7, CB_RA = 4'd8, CB_PC = 4'd9, CB_RD = 4'd10
  } cbus_idx_e;

  typedef enum logic [1:0] {
    ALU_PASS = 2'd0, ALU_ADD = 2'd1, ALU_SUB = 2'd2
  } alu_e;

  typedef struct packed {
    logic                     ldir;
    logic                     pc_inc;
    logic                     ac_inc;
    logic                     ra_inc;
    logic                     rb_inc;
    logic                     rc_inc;
    logic                     read;
    logic                     ram_we;
    logic                     halted;
    logic                     illegal;
    logic [C_BUS_SIG_LEN-1:0] c_bus;
    logic [MUX_SEL_SIG-1:0]   sel;
    logic [ALU_OP_LEN-1:0]    alu_op;
  } ctrl_out_t;

  // One-hot C-bus write enable for a destination register
  function automatic logic [C_BUS_SIG_LEN-1:0] cbus_bit(input cbus_idx_e idx);
    return 11'd1 << idx;
  endfunction

  // Number of EXEC cycles for an opcode; zero means DEC returns straight to F1A
  function automatic logic [2:0] exec_steps(input logic [5:0] op, input logic z);
    logic [2:0] n;
    case (op)
      OP_LDAC, OP_STAC:                        n = 3'd5;
      OP_MVR1, OP_MVR2, OP_MVR3,
      OP_MVAC1, OP_MVAC2, OP_MVAC3,
      OP_ADD, OP_SUB, OP_JMP:                  n = 3'd2;
      OP_INCAC, OP_INCRA, OP_INCRB, OP_INCRC:  n = 3'd1;
      OP_JMPZ:                                 n = z ? 3'd2 : 3'd0;
      default:                                 n = 3'd0;
    endcase
    return n;
  endfunction

  // Two-cycle bus transfer: cycle A drives select only, cycle B adds the write
  function automatic ctrl_out_t xfer(input logic [MUX_SEL_SIG-1:0] src,
                                     input logic [C_BUS_SIG_LEN-1:0] dst,
                                     input logic [ALU_OP_LEN-1:0] alu,
                                     input logic write_cycle);
    ctrl_out_t o;
    o     = '0;
    o.sel = src;
    if (write_cycle) begin
      o.c_bus  = dst;
      o.alu_op = alu;
    end else begin
      o.c_bus  = '0;
      o.alu_op = ALU_PASS;
    end
    return o;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ---------------------------------------------------------------------------
// ctrl_decode
// Pure combinational decode of {state, step, opcode, z} into the control
// output bundle, plus a flag marking the last EXEC step of the instruction.
// Ports:
//   i_state, i_step, i_opcode, i_z : current FSM position and instruction
//   o_ctrl                         : control bundle for this position
//   o_last_step                    : high on the final EXEC step
// ---------------------------------------------------------------------------
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [2:0]                 i_state,
  input  logic [2:0]                 i_step,
  input  logic [INSTRUCTION_LEN-1:0] i_opcode,
  input  logic                       i_z,
  output ctrl_out_t                  o_ctrl,
  output logic                       o_last_step
);

  logic w_wr;

  // Decode control outputs for the current FSM position
  always_comb begin
    o_ctrl      = '0;
    o_last_step = 1'b0;
    // Transfers are two steps long; the odd step is the write cycle
    w_wr        = i_step[0];
    case (i_state)
      ST_F1A:  o_ctrl = xfer(SEL_PC, cbus_bit(CB_AR), ALU_PASS, 1'b0);
      ST_F1B:  o_ctrl = xfer(SEL_PC, cbus_bit(CB_AR), ALU_PASS, 1'b1);
      ST_F2: begin
        o_ctrl.read   = 1'b1;
        o_ctrl.pc_inc = 1'b1;
      end
      ST_F3:   o_ctrl.ldir = 1'b1;
      ST_DEC:  o_ctrl.illegal = !((i_opcode <= OP_JMP) || (i_opcode == OP_HALT));
      ST_HALT: o_ctrl.halted = 1'b1;
      ST_EXEC: begin
        o_last_step = (i_step == (exec_steps(i_opcode, i_z) - 3'd1));
        case (i_opcode)
          OP_LDAC: begin
            case (i_step)
              3'd0, 3'd1: o_ctrl = xfer(SEL_RA, cbus_bit(CB_AR), ALU_PASS, w_wr);
              3'd2:       o_ctrl.read = 1'b1;
              3'd3:       o_ctrl = xfer(SEL_DR, cbus_bit(CB_AC), ALU_PASS, 1'b0);
              3'd4:       o_ctrl = xfer(SEL_DR, cbus_bit(CB_AC), ALU_PASS, 1'b1);
              default:    o_ctrl = '0;
            endcase
          end
          OP_STAC: begin
            case (i_step)
              3'd0, 3'd1: o_ctrl = xfer(SEL_RA, cbus_bit(CB_AR), ALU_PASS, w_wr);
              3'd2:       o_ctrl = xfer(SEL_AC, cbus_bit(CB_DR), ALU_PASS, 1'b0);
              3'd3:       o_ctrl = xfer(SEL_AC, cbus_bit(CB_DR), ALU_PASS, 1'b1);
              3'd4:       o_ctrl.ram_we = 1'b1;
              default:    o_ctrl = '0;
            endcase
          end
          OP_MVR1:  o_ctrl = xfer(SEL_AC, cbus_bit(CB_R1), ALU_PASS, w_wr);
          OP_MVR2:  o_ctrl = xfer(SEL_AC, cbus_bit(CB_R2), ALU_PASS, w_wr);
          OP_MVR3:  o_ctrl = xfer(SEL_AC, cbus_bit(CB_R3), ALU_PASS, w_wr);
          OP_MVAC1: o_ctrl = xfer(SEL_R1, cbus_bit(CB_AC), ALU_PASS, w_wr);
          OP_MVAC2: o_ctrl = xfer(SEL_R2, cbus_bit(CB_AC), ALU_PASS, w_wr);
          OP_MVAC3: o_ctrl = xfer(SEL_R3, cbus_bit(CB_AC), ALU_PASS, w_wr);
          OP_ADD:   o_ctrl = xfer(SEL_R1, cbus_bit(CB_AC), ALU_ADD, w_wr);
          OP_SUB:   o_ctrl = xfer(SEL_R1, cbus_bit(CB_AC), ALU_SUB, w_wr);
          OP_INCAC: o_ctrl.ac_inc = 1'b1;
          OP_INCRA: o_ctrl.ra_inc = 1'b1;
          OP_INCRB: o_ctrl.rb_inc = 1'b1;
          OP_INCRC: o_ctrl.rc_inc = 1'b1;
          OP_JMPZ, OP_JMP: o_ctrl = xfer(SEL_RD, cbus_bit(CB_PC), ALU_PASS, w_wr);
          default:  o_ctrl = '0;
        endcase
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Moore FSM sequencing fetch / decode / execute for the register unit.
// Control outputs are registered from the decode of the current state, so
// each output pattern appears one clock after its FSM position.
// Ports:
//   clk, reset (sync, active-high), start, opcode (IR), z_flag (ALU zero)
//   LDIR, *_INC strobes, read, ram_we, C_bus_ctrl_sig, select, alu_op,
//   halted, illegal
// ---------------------------------------------------------------------------
module control_unit
  import ctrl_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [INSTRUCTION_LEN-1:0] opcode,
  input  logic                       z_flag,
  output logic                       LDIR,
  output logic                       PC_INC,
  output logic                       AC_INC,
  output logic                       RA_INC,
  output logic                       RB_INC,
  output logic                       RC_INC,
  output logic                       read,
  output logic                       ram_we,
  output logic [C_BUS_SIG_LEN-1:0]   C_bus_ctrl_sig,
  output logic [MUX_SEL_SIG-1:0]     select,
  output logic [ALU_OP_LEN-1:0]      alu_op,
  output logic                       halted,
  output logic                       illegal
);

  logic [2:0]                 r_state;
  logic [2:0]                 r_step;
  logic [INSTRUCTION_LEN-1:0] r_opcode;
  logic                       r_z;
  ctrl_out_t                  r_out;

  logic [INSTRUCTION_LEN-1:0] w_dec_opcode;
  logic                       w_dec_z;
  ctrl_out_t                  w_ctrl;
  logic                       w_last_step;

  // IR is live during DEC; EXEC works from the opcode/z latched there
  assign w_dec_opcode = (r_state == ST_DEC) ? opcode : r_opcode;
  assign w_dec_z      = (r_state == ST_DEC) ? z_flag : r_z;

  ctrl_decode u_decode (
    .i_state     (r_state),
    .i_step      (r_step),
    .i_opcode    (w_dec_opcode),
    .i_z         (w_dec_z),
    .o_ctrl      (w_ctrl),
    .o_last_step (w_last_step)
  );

  // FSM, step counter, instruction latch and output register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_step   <= 3'd0;
      r_opcode <= '0;
      r_z      <= 1'b0;
      r_out    <= '0;
    end else begin
      r_out <= w_ctrl;
      case (r_state)
        ST_IDLE: if (start) r_state <= ST_F1A; else r_state <= ST_IDLE;
        ST_F1A:  r_state <= ST_F1B;
        ST_F1B:  r_state <= ST_F2;
        ST_F2:   r_state <= ST_F3;
        ST_F3:   r_state <= ST_DEC;
        ST_DEC: begin
          r_opcode <= opcode;
          r_z      <= z_flag;
          r_step   <= 3'd0;
          if (opcode == OP_HALT) begin
            r_state <= ST_HALT;
          end else if (exec_steps(opcode, z_flag) == 3'd0) begin
            r_state <= ST_F1A;
          end else begin
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (w_last_step) begin
            r_state <= ST_F1A;
            r_step  <= 3'd0;
          end else begin
            r_step  <= r_step + 3'd1;
          end
        end
        ST_HALT: if (start) r_state <= ST_F1A; else r_state <= ST_HALT;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign LDIR           = r_out.ldir;
  assign PC_INC         = r_out.pc_inc;
  assign AC_INC         = r_out.ac_inc;
  assign RA_INC         = r_out.ra_inc;
  assign RB_INC         = r_out.rb_inc;
  assign RC_INC         = r_out.rc_inc;
  assign read           = r_out.read;
  assign ram_we         = r_out.ram_we;
  assign C_bus_ctrl_sig = r_out.c_bus;
  assign select         = r_out.sel;
  assign alu_op         = r_out.alu_op;
  assign halted         = r_out.halted;
  assign illegal        = r_out.illegal;

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
// Directed bench for control_unit: steps clock by clock and compares the full
// output vector against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  opcode;
  logic        z_flag;
  logic        LDIR, PC_INC, AC_INC, RA_INC, RB_INC, RC_INC;
  logic        read, ram_we, halted, illegal;
  logic [10:0] C_bus_ctrl_sig;
  logic [3:0]  select;
  logic [1:0]  alu_op;

  int n_total = 0;
  int n_bad   = 0;

  // strobe vector order: LDIR PC_INC AC_INC RA_INC RB_INC RC_INC read ram_we halted illegal
  localparam logic [9:0] B_NONE  = 10'h000;
  localparam logic [9:0] B_LDIR  = 10'h200;
  localparam logic [9:0] B_PCINC = 10'h100;
  localparam logic [9:0] B_ACINC = 10'h080;
  localparam logic [9:0] B_RAINC = 10'h040;
  localparam logic [9:0] B_READ  = 10'h008;
  localparam logic [9:0] B_WE    = 10'h004;
  localparam logic [9:0] B_HALT  = 10'h002;
  localparam logic [9:0] B_ILL   = 10'h001;

  localparam logic [10:0] C_NONE = 11'h000;
  localparam logic [10:0] C_AC   = 11'h001;
  localparam logic [10:0] C_AR   = 11'h002;
  localparam logic [10:0] C_DR   = 11'h004;
  localparam logic [10:0] C_R1   = 11'h020;
  localparam logic [10:0] C_PC   = 11'h200;

  control_unit dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .opcode         (opcode),
    .z_flag         (z_flag),
    .LDIR           (LDIR),
    .PC_INC         (PC_INC),
    .AC_INC         (AC_INC),
    .RA_INC         (RA_INC),
    .RB_INC         (RB_INC),
    .RC_INC         (RC_INC),
    .read           (read),
    .ram_we         (ram_we),
    .C_bus_ctrl_sig (C_bus_ctrl_sig),
    .select         (select),
    .alu_op         (alu_op),
    .halted         (halted),
    .illegal        (illegal)
  );

  always #5 clk = ~clk;

  // Advance one clock and compare every output against the expectation
  task automatic cyc(input string tag, input logic [9:0] strb, input logic [10:0] cb,
                     input logic [3:0] sel, input logic [1:0] alu);
    logic [26:0] obs;
    logic [26:0] exp;
    @(posedge clk);
    #1;
    obs = {LDIR, PC_INC, AC_INC, RA_INC, RB_INC, RC_INC, read, ram_we, halted, illegal,
           C_bus_ctrl_sig, select, alu_op};
    exp = {strb, cb, sel, alu};
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Five fetch/decode cycles with the given IR contents
  task automatic fetch(input logic [5:0] op, input logic z, input logic ill);
    opcode = op;
    z_flag = z;
    cyc("f1a", B_NONE, C_NONE, 4'd0, 2'd0);
    cyc("f1b", B_NONE, C_AR,   4'd0, 2'd0);
    cyc("f2",  B_READ | B_PCINC, C_NONE, 4'd0, 2'd0);
    cyc("f3",  B_LDIR, C_NONE, 4'd0, 2'd0);
    cyc("dec", ill ? B_ILL : B_NONE, C_NONE, 4'd0, 2'd0);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    opcode = 6'h00;
    z_flag = 1'b0;
    cyc("rst0", B_NONE, C_NONE, 4'd0, 2'd0);
    cyc("rst1", B_NONE, C_NONE, 4'd0, 2'd0);
    reset = 1'b0;
    cyc("idle", B_NONE, C_NONE, 4'd0, 2'd0);
    start = 1'b1;
    cyc("idle_start", B_NONE, C_NONE, 4'd0, 2'd0);
    // start stays high through the first fetch; it must have no effect there
    fetch(6'h00, 1'b0, 1'b0);
    start = 1'b0;

    // LDAC
    fetch(6'h01, 1'b0, 1'b0);
    cyc("ldac_a",  B_NONE, C_NONE, 4'd5, 2'd0);
    cyc("ldac_b",  B_NONE, C_AR,   4'd5, 2'd0);
    cyc("ldac_rd", B_READ, C_NONE, 4'd0, 2'd0);
    cyc("ldac_c",  B_NONE, C_NONE, 4'd1, 2'd0);
    cyc("ldac_d",  B_NONE, C_AC,   4'd1, 2'd0);

    // SUB
    fetch(6'h0A, 1'b0, 1'b0);
    cyc("sub_a", B_NONE, C_NONE, 4'd2, 2'd0);
    cyc("sub_b", B_NONE, C_AC,   4'd2, 2'd2);

    // ADD
    fetch(6'h09, 1'b0, 1'b0);
    cyc("add_a", B_NONE, C_NONE, 4'd2, 2'd0);
    cyc("add_b", B_NONE, C_AC,   4'd2, 2'd1);

    // JMPZ taken, then not taken (next fetch directly follows DEC)
    fetch(6'h0F, 1'b1, 1'b0);
    cyc("jmpz1_a", B_NONE, C_NONE, 4'd8, 2'd0);
    cyc("jmpz1_b", B_NONE, C_PC,   4'd8, 2'd0);
    fetch(6'h0F, 1'b0, 1'b0);

    // STAC
    fetch(6'h02, 1'b0, 1'b0);
    cyc("stac_a",  B_NONE, C_NONE, 4'd5, 2'd0);
    cyc("stac_b",  B_NONE, C_AR,   4'd5, 2'd0);
    cyc("stac_c",  B_NONE, C_NONE, 4'd9, 2'd0);
    cyc("stac_d",  B_NONE, C_DR,   4'd9, 2'd0);
    cyc("stac_we", B_WE,   C_NONE, 4'd0, 2'd0);

    // MVR1, MVAC2, INCRA, JMP
    fetch(6'h03, 1'b0, 1'b0);
    cyc("mvr1_a", B_NONE, C_NONE, 4'd9, 2'd0);
    cyc("mvr1_b", B_NONE, C_R1,   4'd9, 2'd0);
    fetch(6'h07, 1'b0, 1'b0);
    cyc("mvac2_a", B_NONE, C_NONE, 4'd3, 2'd0);
    cyc("mvac2_b", B_NONE, C_AC,   4'd3, 2'd0);
    fetch(6'h0C, 1'b0, 1'b0);
    cyc("incra", B_RAINC, C_NONE, 4'd0, 2'd0);
    fetch(6'h10, 1'b1, 1'b0);
    cyc("jmp_a", B_NONE, C_NONE, 4'd8, 2'd0);
    cyc("jmp_b", B_NONE, C_PC,   4'd8, 2'd0);

    // Undefined opcode: illegal only in the DEC-derived cycle, then refetch
    fetch(6'h2A, 1'b0, 1'b1);

    // HALT: hold for 20 cycles, then start resumes fetching
    fetch(6'h3F, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc("halt_hold", B_HALT, C_NONE, 4'd0, 2'd0);
    end
    start = 1'b1;
    cyc("halt_exit", B_HALT, C_NONE, 4'd0, 2'd0);
    start = 1'b0;
    fetch(6'h0B, 1'b0, 1'b0);
    cyc("incac", B_ACINC, C_NONE, 4'd0, 2'd0);

    // Reset in STAC step 2: no further strobes, stays IDLE until start
    fetch(6'h02, 1'b0, 1'b0);
    cyc("stac2_a", B_NONE, C_NONE, 4'd5, 2'd0);
    cyc("stac2_b", B_NONE, C_AR,   4'd5, 2'd0);
    reset = 1'b1;
    cyc("abort_rst", B_NONE, C_NONE, 4'd0, 2'd0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc("abort_idle", B_NONE, C_NONE, 4'd0, 2'd0);
    end
    start = 1'b1;
    cyc("abort_start", B_NONE, C_NONE, 4'd0, 2'd0);
    start = 1'b0;
    fetch(6'h00, 1'b0, 1'b0);
    cyc("tail", B_NONE, C_NONE, 4'd0, 2'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
